// File: rtl/wb_dma_copy.sv
// Wishbone word-copy DMA: register slave port plus a read-then-write single-cycle master.
// Optional pattern-fill mode is compiled in with `define WB_DMA_FILL_EN.
module wb_dma_copy #(
    parameter int unsigned LEN_W = 16
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        irq
);

    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_GAP,
        S_WR,
        S_WR_GAP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DW-1:0]    r_src;
    logic [DW-1:0]    r_dst;
    logic [LEN_W-1:0] r_len;
    logic             r_done;
    logic             r_err;
    logic             r_ie;
    logic             r_irq;
    logic             r_ack;
    logic [DW-1:0]    r_rdat;
    logic             r_wbm_cyc;
    logic             r_wbm_we;
    logic [DW-1:0]    r_wbm_adr;
    logic [DW-1:0]    r_wbm_dat;

    logic          w_acc;
    logic          w_wr;
    logic          w_busy;
    logic          w_wr_src;
    logic          w_wr_dst;
    logic          w_wr_len;
    logic          w_wr_ctrl;
    logic          w_start;
    logic          w_fill;
    logic          w_fill_req;
    logic          w_rd_beat;
    logic          w_wr_beat;
    logic          w_set_done;
    logic          w_set_err;
    logic          w_done_nxt;
    logic          w_err_nxt;
    logic          w_ie_nxt;
    logic          w_bus_nxt;
    logic          w_fill_load;
    logic [DW-1:0] w_rd_mux;
    logic          w_unused;

    // Slave decode: one access per ack, pointer/length writes only while idle
    assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr      = w_acc & wb_we_i;
    assign w_busy    = (r_state != S_IDLE);
    assign w_wr_src  = w_wr & ~w_busy & (wb_adr_i[3:2] == 2'd0);
    assign w_wr_dst  = w_wr & ~w_busy & (wb_adr_i[3:2] == 2'd1);
    assign w_wr_len  = w_wr & ~w_busy & (wb_adr_i[3:2] == 2'd2);
    assign w_wr_ctrl = w_wr & (wb_adr_i[3:2] == 2'd3);
    assign w_start   = w_wr_ctrl & wb_dat_i[0] & ~w_busy;

`ifdef WB_DMA_FILL_EN
    logic r_fill;

    // Mode is frozen for the duration of a transfer
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_fill <= 1'b0;
        end else if (w_wr_ctrl && !w_busy) begin
            r_fill <= wb_dat_i[5];
        end
    end

    assign w_fill     = r_fill;
    assign w_fill_req = wb_dat_i[5];
`else
    assign w_fill     = 1'b0;
    assign w_fill_req = 1'b0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (wb_adr_i[3:2])
            2'd0:    w_rd_mux = r_src;
            2'd1:    w_rd_mux = r_dst;
            2'd2:    w_rd_mux = DW'(r_len);
            default: w_rd_mux = DW'({w_fill, r_ie, r_err, r_done, w_busy, 1'b0});
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_beat   = 1'b0;
        w_wr_beat   = 1'b0;
        w_set_done  = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (r_len == '0) begin
                        w_set_done = 1'b1;
                    end else begin
                        w_state_nxt = w_fill_req ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                if (wbm_err_i) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (wbm_ack_i) begin
                    w_rd_beat   = 1'b1;
                    w_state_nxt = S_RD_GAP;
                end
            end
            S_RD_GAP: w_state_nxt = S_WR;
            S_WR: begin
                if (wbm_err_i) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (wbm_ack_i) begin
                    w_wr_beat = 1'b1;
                    if (r_len == LEN_W'(1)) begin
                        w_set_done  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WR_GAP;
                    end
                end
            end
            S_WR_GAP: w_state_nxt = w_fill ? S_WR : S_RD;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Hardware set beats a same-cycle software clear
    assign w_done_nxt  = w_set_done | (r_done & ~(w_wr_ctrl & wb_dat_i[2]));
    assign w_err_nxt   = w_set_err  | (r_err  & ~(w_wr_ctrl & wb_dat_i[3]));
    assign w_ie_nxt    = w_wr_ctrl ? wb_dat_i[4] : r_ie;
    assign w_bus_nxt   = (w_state_nxt == S_RD) | (w_state_nxt == S_WR);
    assign w_fill_load = (w_state_nxt == S_WR) & ((r_state == S_IDLE) | (r_state == S_WR_GAP));

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ie      <= 1'b0;
            r_irq     <= 1'b0;
            r_ack     <= 1'b0;
            r_rdat    <= '0;
            r_wbm_cyc <= 1'b0;
            r_wbm_we  <= 1'b0;
            r_wbm_adr <= '0;
            r_wbm_dat <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) begin
                r_rdat <= w_rd_mux;
            end

            if (w_wr_src) begin
                r_src <= wb_dat_i;
            end else if (w_wr_beat && !w_fill) begin
                r_src <= r_src + DW'(4);
            end

            if (w_wr_dst) begin
                r_dst <= {wb_dat_i[DW-1:2], 2'b00};
            end else if (w_wr_beat) begin
                r_dst <= r_dst + DW'(4);
            end

            if (w_wr_len) begin
                r_len <= wb_dat_i[LEN_W-1:0];
            end else if (w_wr_beat) begin
                r_len <= r_len - LEN_W'(1);
            end

            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            r_ie   <= w_ie_nxt;
            r_irq  <= w_ie_nxt & (w_done_nxt | w_err_nxt);

            // Master strobes follow the next state so they line up with it
            r_wbm_cyc <= w_bus_nxt;
            r_wbm_we  <= (w_state_nxt == S_WR);
            if (w_state_nxt == S_RD) begin
                r_wbm_adr <= {r_src[DW-1:2], 2'b00};
            end else if (w_state_nxt == S_WR) begin
                r_wbm_adr <= {r_dst[DW-1:2], 2'b00};
            end else begin
                r_wbm_adr <= '0;
            end

            if (w_rd_beat) begin
                r_wbm_dat <= wbm_dat_i;
            end else if (w_fill_load) begin
                r_wbm_dat <= r_src;
            end
        end
    end

    assign wb_dat_o  = r_rdat;
    assign wb_ack_o  = r_ack;
    assign wb_err_o  = 1'b0;
    assign wb_rty_o  = 1'b0;
    assign wbm_adr_o = r_wbm_adr;
    assign wbm_dat_o = r_wbm_dat;
    assign wbm_sel_o = 4'hf;
    assign wbm_we_o  = r_wbm_we;
    assign wbm_cyc_o = r_wbm_cyc;
    assign wbm_stb_o = r_wbm_cyc;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;
    assign irq       = r_irq;

    assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_dma_copy.sv
// Self-checking bench for wb_dma_copy: CPU register accesses, a memory-slave model
// returning address-derived data, and a transfer-list reference model.
module tb_wb_dma_copy;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] s_dat;
    logic        s_ack, s_err;
    logic        irq;

    wb_dma_copy dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err),
        .irq(irq)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t        log_q[$];
    logic [31:0] seed;
    bit          slv_wait;
    int          err_at_rd;
    int          rd_count;
    int          gap_viol, const_viol, cyc_cnt, ack_dbl;
    logic        saw_resp;
    int          n_checks, n_pass;

    // Memory contents: a fixed scramble of the word address
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ seed;
    endfunction

    // Memory slave: random wait states, optional error on a chosen read
    always @(posedge wb_clk) begin
        if (wb_rst) begin
            s_ack    <= 1'b0;
            s_err    <= 1'b0;
            s_dat    <= '0;
            rd_count <= rd_count;
        end else begin
            if (s_ack && wbm_cyc_o && wbm_stb_o) begin
                log_q.push_back('{we: wbm_we_o, adr: wbm_adr_o, dat: wbm_we_o ? wbm_dat_o : s_dat});
            end
            s_ack <= 1'b0;
            s_err <= 1'b0;
            if (wbm_cyc_o && wbm_stb_o && !s_ack && !s_err &&
                (!slv_wait || $urandom_range(0, 2) == 0)) begin
                if (!wbm_we_o && err_at_rd == rd_count + 1) s_err <= 1'b1;
                else s_ack <= 1'b1;
                if (!wbm_we_o) begin
                    rd_count <= rd_count + 1;
                    s_dat    <= pat(wbm_adr_o);
                end
            end
        end
    end

    always @(posedge wb_clk) begin
        if (saw_resp && wbm_cyc_o) gap_viol <= gap_viol + 1;
        saw_resp <= (s_ack || s_err) && wbm_cyc_o && !wb_rst;
        if (wbm_cyc_o) cyc_cnt <= cyc_cnt + 1;
        if ((wbm_cyc_o && (wbm_sel_o != 4'hf || wbm_cti_o != 3'b000 || wbm_bte_o != 2'b00 ||
             wbm_adr_o[1:0] != 2'b00 || wbm_stb_o != wbm_cyc_o)) || wb_err_o || wb_rty_o)
            const_viol <= const_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        logic [31:0] rnd;
        bit          got;
        rnd = $urandom();
        got = 1'b0;
        @(negedge wb_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = {rnd[31:4], a}; wb_dat_i = d; wb_sel_i = 4'hf;
        for (int k = 0; k < 20; k++) begin
            @(posedge wb_clk); #1;
            if (wb_ack_o) begin got = 1'b1; break; end
        end
        q = wb_dat_o;
        check("slave_ack", 32'(got), 32'd1);
        @(posedge wb_clk); #1;
        if (wb_ack_o) ack_dbl++;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'h0, q);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] q;
        rd(a, q);
        check(tag, q, exp);
    endtask

    task automatic wait_idle();
        logic [31:0] q;
        bit          ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rd(4'hc, q);
            if (!q[1]) begin ok = 1'b1; break; end
        end
        check("wait_idle", 32'(ok), 32'd1);
    endtask

    // Reference: a copy of n words is n (read src+4i, write dst+4i) pairs; fill is n writes
    task automatic check_log(input string tag, input int start, input logic [31:0] src,
                             input logic [31:0] dst, input int n, input bit fill);
        int          exp_n;
        int          idx;
        logic [31:0] a_s, a_d;
        exp_n = fill ? n : 2 * n;
        check({tag, "_count"}, 32'(log_q.size() - start), 32'(exp_n));
        for (int i = 0; i < n; i++) begin
            a_s = src + 32'(4 * i);
            a_d = dst + 32'(4 * i);
            idx = start + (fill ? i : 2 * i);
            if (!fill && idx < log_q.size()) begin
                check($sformatf("%s_rd%0d", tag, i), {log_q[idx].adr[31:1], log_q[idx].we},
                      {a_s[31:2], 2'b00});
            end
            if (fill) begin
                if (idx < log_q.size()) begin
                    check($sformatf("%s_wa%0d", tag, i), {log_q[idx].adr[31:1], ~log_q[idx].we}, a_d);
                    check($sformatf("%s_wd%0d", tag, i), log_q[idx].dat, src);
                end
            end else if (idx + 1 < log_q.size()) begin
                check($sformatf("%s_wa%0d", tag, i), {log_q[idx+1].adr[31:1], ~log_q[idx+1].we}, a_d);
                check($sformatf("%s_wd%0d", tag, i), log_q[idx+1].dat, pat({a_s[31:2], 2'b00}));
            end
        end
    endtask

    task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int n);
        int start;
        wr(4'h0, src); wr(4'h4, dst); wr(4'h8, 32'(n));
        start = log_q.size();
        wr(4'hc, 32'h1);
        wait_idle();
        check_log(tag, start, src, dst, n, 1'b0);
        rd_check({tag, "_ctrl"}, 4'hc, 32'h4);
        rd_check({tag, "_src"}, 4'h0, src + 32'(4 * n));
        rd_check({tag, "_dst"}, 4'h4, dst + 32'(4 * n));
        rd_check({tag, "_len"}, 4'h8, 32'h0);
        wr(4'hc, 32'hc);
    endtask

    initial begin
        logic [31:0] q, src, dst;
        int          start, rc, cc, n;
        bit          seen;
        n_checks = 0; n_pass = 0;
        gap_viol = 0; const_viol = 0; cyc_cnt = 0; ack_dbl = 0; rd_count = 0;
        saw_resp = 1'b0;
        seed = $urandom(); slv_wait = 1'b0; err_at_rd = 0;
        wb_rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_madr", wbm_adr_o, 32'd0);
        wb_rst = 1'b0;
        rd_check("rst_src", 4'h0, 32'h0);
        rd_check("rst_ctrl", 4'hc, 32'h0);

        // Basic 4-word copy, then DST low bits read as zero
        run_copy("copy4", 32'h100, 32'h200, 4);
        wr(4'h4, 32'h0000_0207);
        rd_check("dst_align", 4'h4, 32'h0000_0204);

        // Zero-length start: DONE without any bus traffic
        cc = cyc_cnt;
        wr(4'h8, 32'h0); wr(4'hc, 32'h1);
        rd_check("len0_ctrl", 4'hc, 32'h4);
        check("len0_nobus", 32'(cyc_cnt - cc), 32'd0);
        wr(4'hc, 32'h4);

        // Error on the second read of a 3-word transfer
        err_at_rd = rd_count + 2;
        start = log_q.size();
        wr(4'h0, 32'h500); wr(4'h4, 32'h600); wr(4'h8, 32'd3); wr(4'hc, 32'h1);
        wait_idle();
        err_at_rd = 0;
        check_log("err", start, 32'h500, 32'h600, 1, 1'b0);
        check("err_count", 32'(log_q.size() - start), 32'd2);
        rd_check("err_ctrl", 4'hc, 32'h8);
        rd_check("err_src", 4'h0, 32'h504);
        rd_check("err_len", 4'h8, 32'd2);
        wr(4'hc, 32'h8);

        // Register writes and START while busy are ignored
        slv_wait = 1'b1;
        wr(4'h0, 32'h700); wr(4'h4, 32'h800); wr(4'h8, 32'd4);
        start = log_q.size();
        wr(4'hc, 32'h1);
        wr(4'h4, 32'hdead_0000); wr(4'hc, 32'h1);
        rd(4'hc, q);
        check("busy_bit", q & 32'h2, 32'h2);
        wait_idle();
        check_log("busy", start, 32'h700, 32'h800, 4, 1'b0);
        rd_check("busy_dst", 4'h4, 32'h810);
        wr(4'hc, 32'hc);

        // Pointer wrap and randomized copies
        run_copy("wrap", 32'hffff_fff8, 32'h0900_0000, 4);
        for (int t = 0; t < 6; t++) begin
            n   = (t == 0) ? 1 : $urandom_range(2, 7);
            slv_wait = ($urandom_range(0, 1) == 1);
            src = 32'h1000_0000 + 32'(t * 32'h1000) + 32'($urandom_range(0, 63) * 4);
            dst = 32'h4000_0000 + 32'(t * 32'h1000) + 32'($urandom_range(0, 63) * 4);
            run_copy($sformatf("rnd%0d", t), src, dst, n);
        end

        // Interrupt follows IE & DONE; clearing DONE drops it
        wr(4'hc, 32'h1c);
        wr(4'h0, 32'h2000); wr(4'h4, 32'h3000); wr(4'h8, 32'd2);
        wr(4'hc, 32'h11);
        wait_idle();
        check("irq_set", 32'(irq), 32'd1);
        rd_check("irq_ctrl", 4'hc, 32'h14);
        wr(4'hc, 32'h04);
        check("irq_clr", 32'(irq), 32'd0);
        rd_check("irq_ctrl2", 4'hc, 32'h0);

`ifdef WB_DMA_FILL_EN
        rc = rd_count;
        start = log_q.size();
        wr(4'h0, 32'ha5a5_a5a5); wr(4'h4, 32'h300); wr(4'h8, 32'd2);
        wr(4'hc, 32'h21);
        wait_idle();
        check_log("fill", start, 32'ha5a5_a5a5, 32'h300, 2, 1'b1);
        check("fill_noread", 32'(rd_count - rc), 32'd0);
        rd_check("fill_ctrl", 4'hc, 32'h24);
        rd_check("fill_src", 4'h0, 32'ha5a5_a5a5);
        rd_check("fill_dst", 4'h4, 32'h308);
        wr(4'hc, 32'h0c);
`else
        wr(4'hc, 32'h20);
        rd_check("nofill_ctrl", 4'hc, 32'h0);
        rc = rd_count;
        check("nofill_rc", 32'(rc), 32'(rd_count));
`endif

        // Reset in the middle of a write beat
        slv_wait = 1'b1;
        wr(4'hc, 32'h1c);
        wr(4'h0, 32'h5000); wr(4'h4, 32'h6000); wr(4'h8, 32'd4);
        wr(4'hc, 32'h11);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge wb_clk); #1;
            if (wbm_cyc_o && wbm_we_o) begin seen = 1'b1; break; end
        end
        check("rst_wr_seen", 32'(seen), 32'd1);
        wb_rst = 1'b1;
        @(posedge wb_clk); #1;
        check("mrst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("mrst_we", 32'(wbm_we_o), 32'd0);
        check("mrst_adr", wbm_adr_o, 32'd0);
        check("mrst_dat", wbm_dat_o, 32'd0);
        check("mrst_irq", 32'(irq), 32'd0);
        wb_rst = 1'b0;
        rd_check("mrst_src", 4'h0, 32'h0);
        rd_check("mrst_dst", 4'h4, 32'h0);
        rd_check("mrst_len", 4'h8, 32'h0);
        rd_check("mrst_ctrl", 4'hc, 32'h0);

        check("bus_gap", 32'(gap_viol), 32'd0);
        check("bus_const", 32'(const_viol), 32'd0);
        check("slave_single_ack", 32'(ack_dbl), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
